// File: rtl/corr_array_wta.sv
// corr_array_wta
//   Stereo correlator with a parametrised number of disparity taps, followed
//   by a serial winner-take-all scanner.
//
//   A left-image shift chain of NDISP taps is correlated against a single
//   right-image register. Each tap produces re*re + im*im through a
//   three-stage pipeline (product, sum, bank). The registered score bank is
//   then scanned one entry per cycle, and the best disparity is reported.
//
//   Build option: define CORR_MIN_SEARCH_EN to report the minimum score
//   instead of the maximum. The datapath and all timing are the same in
//   both builds.
//
// Ports
//   clk, rst_n      rising-edge clock, asynchronous active-low reset
//   wen             sample strobe: shifts the chains and launches a frame
//   d_l_re/d_l_im   left sample (unsigned DW bits each)
//   d_r_re/d_r_im   right sample (unsigned DW bits each)
//   corr_flat       score bank; tap i at bits [i*SW +: SW]
//   bank_valid      one-cycle pulse after the bank updates
//   best_idx        winning tap index
//   best_val        winning score
//   best_valid      one-cycle pulse when best_idx/best_val update
//   busy            scanner is in SCAN
//   overrun         sticky: a scan was aborted by a newer bank
//
// Scanner states
//   state | meaning
//   IDLE  | no scan in progress; best_* hold their last result
//   SCAN  | walking bank[idx], keeping the running winner
module corr_array_wta #(
  parameter int DW    = 8,
  parameter int NDISP = 21,
  parameter int IDXW  = 5,
  localparam int SW   = 2*DW+1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                wen,
  input  logic [DW-1:0]       d_l_re,
  input  logic [DW-1:0]       d_l_im,
  input  logic [DW-1:0]       d_r_re,
  input  logic [DW-1:0]       d_r_im,
  output logic [NDISP*SW-1:0] corr_flat,
  output logic                bank_valid,
  output logic [IDXW-1:0]     best_idx,
  output logic [SW-1:0]       best_val,
  output logic                best_valid,
  output logic                busy,
  output logic                overrun
);

  typedef enum logic {IDLE, SCAN} state_t;

  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NDISP-1);

  logic [DW-1:0]   tap_re  [NDISP];
  logic [DW-1:0]   tap_im  [NDISP];
  logic [DW-1:0]   r_re, r_im;
  logic [2*DW-1:0] prod_re [NDISP];
  logic [2*DW-1:0] prod_im [NDISP];
  logic [SW-1:0]   sum     [NDISP];
  logic [SW-1:0]   bank    [NDISP];
  logic [2:0]      vld;
  logic            bank_load;

  // vld[2] is wen delayed three edges: the sums now reflect that wen's taps.
  assign bank_load = vld[2];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_re       <= '0;
      r_im       <= '0;
      vld        <= '0;
      bank_valid <= 1'b0;
      for (int i = 0; i < NDISP; i++) begin
        tap_re[i]  <= '0;
        tap_im[i]  <= '0;
        prod_re[i] <= '0;
        prod_im[i] <= '0;
        sum[i]     <= '0;
        bank[i]    <= '0;
      end
    end else begin
      vld        <= {vld[1:0], wen};
      bank_valid <= bank_load;
      if (wen) begin
        r_re      <= d_r_re;
        r_im      <= d_r_im;
        tap_re[0] <= d_l_re;
        tap_im[0] <= d_l_im;
        for (int i = 1; i < NDISP; i++) begin
          tap_re[i] <= tap_re[i-1];
          tap_im[i] <= tap_im[i-1];
        end
      end
      for (int i = 0; i < NDISP; i++) begin
        prod_re[i] <= (2*DW)'(tap_re[i]) * (2*DW)'(r_re);
        prod_im[i] <= (2*DW)'(tap_im[i]) * (2*DW)'(r_im);
        sum[i]     <= {1'b0, prod_re[i]} + {1'b0, prod_im[i]};
        if (bank_load) bank[i] <= sum[i];
      end
    end
  end

  for (genvar g = 0; g < NDISP; g++) begin : g_flat
    assign corr_flat[g*SW +: SW] = bank[g];
  end

  // Scanner
  state_t          state, state_nxt;
  logic [IDXW-1:0] idx, idx_nxt, run_idx, run_idx_nxt, best_idx_nxt, cand_idx;
  logic [SW-1:0]   run_val, run_val_nxt, best_val_nxt, cand_val;
  logic            best_valid_nxt, overrun_nxt, better;

`ifdef CORR_MIN_SEARCH_EN
  localparam logic [SW-1:0] RUN_INIT = '1;
  assign better = bank[idx] < run_val;
`else
  localparam logic [SW-1:0] RUN_INIT = '0;
  assign better = bank[idx] > run_val;
`endif

  assign busy = (state == SCAN);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      idx        <= '0;
      run_idx    <= '0;
      run_val    <= '0;
      best_idx   <= '0;
      best_val   <= '0;
      best_valid <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      state      <= state_nxt;
      idx        <= idx_nxt;
      run_idx    <= run_idx_nxt;
      run_val    <= run_val_nxt;
      best_idx   <= best_idx_nxt;
      best_val   <= best_val_nxt;
      best_valid <= best_valid_nxt;
      overrun    <= overrun_nxt;
    end
  end

  always_comb begin
    state_nxt      = state;
    idx_nxt        = idx;
    run_idx_nxt    = run_idx;
    run_val_nxt    = run_val;
    best_idx_nxt   = best_idx;
    best_val_nxt   = best_val;
    best_valid_nxt = 1'b0;
    overrun_nxt    = overrun;
    // Strict compare keeps the earlier index on ties.
    cand_val       = better ? bank[idx] : run_val;
    cand_idx       = better ? idx : run_idx;
    // A new bank wins over everything, including the final scan edge.
    if (bank_load) begin
      state_nxt   = SCAN;
      idx_nxt     = '0;
      run_idx_nxt = '0;
      run_val_nxt = RUN_INIT;
      if (state == SCAN) overrun_nxt = 1'b1;
    end else if (state == SCAN) begin
      run_val_nxt = cand_val;
      run_idx_nxt = cand_idx;
      idx_nxt     = idx + 1'b1;
      if (idx == LAST_IDX) begin
        state_nxt      = IDLE;
        idx_nxt        = '0;
        best_idx_nxt   = cand_idx;
        best_val_nxt   = cand_val;
        best_valid_nxt = 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_corr_array_wta.sv
module tb_corr_array_wta;
  localparam int DW    = 8;
  localparam int NDISP = 21;
  localparam int IDXW  = 5;
  localparam int SW    = 2*DW+1;
`ifdef CORR_MIN_SEARCH_EN
  localparam bit MIN_SEARCH = 1'b1;
`else
  localparam bit MIN_SEARCH = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic wen = 1'b0;
  logic [DW-1:0] d_l_re = '0, d_l_im = '0, d_r_re = '0, d_r_im = '0;
  logic [NDISP*SW-1:0] corr_flat;
  logic bank_valid, best_valid, busy, overrun;
  logic [IDXW-1:0] best_idx;
  logic [SW-1:0] best_val;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  corr_array_wta #(.DW(DW), .NDISP(NDISP), .IDXW(IDXW)) dut (
    .clk(clk), .rst_n(rst_n), .wen(wen),
    .d_l_re(d_l_re), .d_l_im(d_l_im), .d_r_re(d_r_re), .d_r_im(d_r_im),
    .corr_flat(corr_flat), .bank_valid(bank_valid),
    .best_idx(best_idx), .best_val(best_val), .best_valid(best_valid),
    .busy(busy), .overrun(overrun)
  );

  task automatic chk(input string name, input longint act, input longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Frame-level reference: each wen snapshots the chain and schedules a bank
  // of scores three edges later; each bank starts a scan whose result is due
  // NDISP edges later unless a newer bank arrives first.
  int ml_re [NDISP];
  int ml_im [NDISP];
  int mr_re, mr_im;
  int cyc, m_final, w_idx;
  longint w_val, s;
  int fq_due [$];
  logic [NDISP*SW-1:0] fq_sc [$];
  logic [NDISP*SW-1:0] m_flat, nf;
  bit m_bank_v, m_best_v, m_busy, m_ovr;
  int m_best_idx;
  longint m_best_val;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cyc = 0;
      for (int i = 0; i < NDISP; i++) begin ml_re[i] = 0; ml_im[i] = 0; end
      mr_re = 0; mr_im = 0;
      fq_due.delete(); fq_sc.delete();
      m_flat = '0; m_bank_v = 0; m_best_v = 0; m_busy = 0; m_ovr = 0;
      m_best_idx = 0; m_best_val = 0;
    end else begin
      cyc++;
      m_bank_v = 0;
      m_best_v = 0;
      if (wen) begin
        for (int i = NDISP-1; i > 0; i--) begin ml_re[i] = ml_re[i-1]; ml_im[i] = ml_im[i-1]; end
        ml_re[0] = int'(d_l_re); ml_im[0] = int'(d_l_im);
        mr_re = int'(d_r_re); mr_im = int'(d_r_im);
        for (int i = 0; i < NDISP; i++) nf[i*SW +: SW] = SW'(ml_re[i]*mr_re + ml_im[i]*mr_im);
        fq_due.push_back(cyc + 3);
        fq_sc.push_back(nf);
      end
      if (fq_due.size() > 0 && fq_due[0] == cyc) begin
        fq_due.delete(0);
        m_flat = fq_sc.pop_front();
        m_bank_v = 1;
        if (m_busy) m_ovr = 1;
        m_busy = 1;
        m_final = cyc + NDISP;
        w_val = longint'(m_flat[0 +: SW]);
        for (int i = 0; i < NDISP; i++) begin
          s = longint'(m_flat[i*SW +: SW]);
          if (MIN_SEARCH ? (s < w_val) : (s > w_val)) w_val = s;
        end
        w_idx = -1;
        for (int i = 0; i < NDISP; i++)
          if (w_idx < 0 && longint'(m_flat[i*SW +: SW]) == w_val) w_idx = i;
      end else if (m_busy && cyc == m_final) begin
        m_best_v = 1;
        m_best_idx = w_idx;
        m_best_val = w_val;
        m_busy = 0;
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      total++;
      if (corr_flat !== m_flat) begin
        bad++;
        $display("FAIL corr_flat: got %h expected %h", corr_flat, m_flat);
      end
      chk("bank_valid", bank_valid, m_bank_v);
      chk("best_valid", best_valid, m_best_v);
      chk("best_idx", best_idx, m_best_idx);
      chk("best_val", best_val, m_best_val);
      chk("busy", busy, m_busy);
      chk("overrun", overrun, m_ovr);
    end
  end

  task automatic do_wen(input int lre, input int lim, input int rre, input int rim);
    wen = 1'b1;
    d_l_re = DW'(lre); d_l_im = DW'(lim); d_r_re = DW'(rre); d_r_im = DW'(rim);
    @(posedge clk); #1;
    wen = 1'b0;
  endtask

  task automatic idle(input int n, output int pulses);
    pulses = 0;
    repeat (n) begin
      @(negedge clk);
      if (bank_valid || best_valid) pulses++;
      @(posedge clk); #1;
    end
  endtask

  // Called right after the last wen: latency counts edges after that wen edge.
  task automatic wait_best(input string name, input int exp_lat, input longint exp_idx,
                           input longint exp_val);
    int got;
    got = -1;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (best_valid) begin got = k; break; end
      @(posedge clk); #1;
    end
    chk({name, " latency"}, got, exp_lat);
    chk({name, " best_idx"}, best_idx, exp_idx);
    chk({name, " best_val"}, best_val, exp_val);
    @(posedge clk); #1;
  endtask

  int p;
  logic [NDISP*SW-1:0] snap_flat;
  logic [IDXW-1:0] snap_idx;
  logic [SW-1:0] snap_val;

  initial begin
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("reset busy", busy, 0);
    chk("reset overrun", overrun, 0);
    chk("reset best_val", best_val, 0);
    @(posedge clk); #1;

    for (int k = 0; k < NDISP; k++) do_wen(3, 4, 3, 4);
    wait_best("uniform", NDISP+3, 0, 25);
    chk("uniform tap20", corr_flat[20*SW +: SW], 25);

    for (int k = 1; k <= NDISP; k++) do_wen(k, 0, 2, 0);
    wait_best("ramp", NDISP+3, MIN_SEARCH ? 20 : 0, MIN_SEARCH ? 2 : 42);
    chk("ramp tap5", corr_flat[5*SW +: SW], 32);

    for (int k = 0; k < NDISP; k++) do_wen(255, 255, 255, 255);
    wait_best("fullscale", NDISP+3, 0, 130050);
    chk("fullscale tap0", corr_flat[0 +: SW], 130050);

    snap_flat = corr_flat; snap_idx = best_idx; snap_val = best_val;
    idle(50, p);
    chk("hold pulses", p, 0);
    chk("hold corr_flat stable", (corr_flat == snap_flat) ? 1 : 0, 1);
    chk("hold best_idx", best_idx, snap_idx);
    chk("hold best_val", best_val, snap_val);

    do_wen(5, 6, 7, 8); do_wen(5, 6, 7, 8); do_wen(5, 6, 7, 8);
    idle(5, p);
    chk("pre-reset busy", busy, 1);
    chk("pre-reset overrun sticky", overrun, 1);
    #3 rst_n = 1'b0;
    #1;
    chk("async rst busy", busy, 0);
    chk("async rst overrun", overrun, 0);
    chk("async rst best_val", best_val, 0);
    chk("async rst best_idx", best_idx, 0);
    chk("async rst best_valid", best_valid, 0);
    chk("async rst bank_valid", bank_valid, 0);
    chk("async rst corr_flat zero", (corr_flat == '0) ? 1 : 0, 1);
    @(posedge clk); #1 rst_n = 1'b1;
    idle(40, p);
    chk("post-reset pulses", p, 0);

    do_wen(10, 0, 1, 0);
    idle(9, p);
    chk("overrun before abort", overrun, 0);
    do_wen(1, 1, 5, 5);
    wait_best("overrun", NDISP+3, MIN_SEARCH ? 2 : 1, MIN_SEARCH ? 0 : 50);
    chk("overrun set", overrun, 1);
    idle(30, p);
    chk("overrun extra pulses", p, 0);
    chk("overrun still set", overrun, 1);

    for (int k = 0; k < 400; k++) begin
      if ($urandom_range(0, 3) == 0)
        do_wen(int'($urandom_range(0, 255)), int'($urandom_range(0, 255)),
               int'($urandom_range(0, 255)), int'($urandom_range(0, 255)));
      else begin
        @(posedge clk); #1;
      end
    end
    for (int k = 0; k < NDISP; k++)
      do_wen(int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), 2, 1);
    idle(40, p);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
